// File: rtl/l1d_line_ctrl.sv
// L1D line/bus controller: turns L1 request strobes into single-beat transfers on a 64-bit req/ack bus.
// Optional ack watchdog is enabled by defining L1C_BUS_TIMEOUT_EN.
module l1d_line_ctrl #(
  parameter int unsigned LINE_BEATS = 2048,
  parameter int unsigned CNT_W      = 11,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_through_req,
  input  logic             read_req,
  input  logic             read_line_req,
  input  logic             write_line_req,
  input  logic [3:0]       L1_size,
  input  logic [63:0]      pa,
  input  logic [63:0]      wt_data,
  output logic [63:0]      line_data,
  output logic [CNT_W-1:0] addr_count,
  output logic             line_write,
  output logic             cache_entry_refill,
  output logic             trans_rdy,
  output logic             bus_error,
  output logic             bus_req,
  output logic             bus_we,
  output logic [63:0]      bus_addr,
  output logic [3:0]       bus_size,
  output logic [63:0]      bus_wdata,
  input  logic [63:0]      bus_rdata,
  input  logic             bus_ack,
  input  logic             bus_err
);

  localparam int unsigned      OFS_W     = CNT_W + 3;
  localparam int unsigned      TAG_W     = 64 - OFS_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);
  localparam logic [3:0]       SIZE_DW   = 4'b1000;

  if (LINE_BEATS != (32'd1 << CNT_W) || LINE_BEATS < 2 || TIMEOUT == 0) begin : g_param_check
    $error("l1d_line_ctrl: CNT_W must equal log2(LINE_BEATS), LINE_BEATS >= 2, TIMEOUT > 0");
  end

  typedef enum logic [2:0] {
    IDLE, RD_ONE, WR_ONE, RD_LINE, WB_FETCH, WB_BEAT, DONE, ERR
  } state_e;

  state_e           state_q;
  logic [TAG_W-1:0] tag_q;
  logic             fetch_wait_q;
  logic             timeout_c;
  logic             bus_fail_c;
  logic             bus_ok_c;

`ifdef L1C_BUS_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [WD_W-1:0] wd_q;

  // Watchdog counts unanswered request cycles; the TIMEOUT-th one is treated as bus_err.
  assign timeout_c = bus_req && !bus_ack && (wd_q == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || !bus_req || bus_ack) wd_q <= '0;
    else                            wd_q <= wd_q + WD_W'(1);
  end
`else
  assign timeout_c = 1'b0;
`endif

  assign bus_fail_c = bus_req && (bus_err || timeout_c);
  assign bus_ok_c   = bus_req && bus_ack && !bus_err;

  function automatic logic [63:0] beat_addr(input logic [TAG_W-1:0] tag,
                                            input logic [CNT_W-1:0] idx);
    return {tag, idx, 3'b000};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      tag_q              <= '0;
      fetch_wait_q       <= 1'b0;
      line_data          <= '0;
      addr_count         <= '0;
      line_write         <= 1'b0;
      cache_entry_refill <= 1'b0;
      trans_rdy          <= 1'b0;
      bus_error          <= 1'b0;
      bus_req            <= 1'b0;
      bus_we             <= 1'b0;
      bus_addr           <= '0;
      bus_size           <= '0;
      bus_wdata          <= '0;
    end else begin
      line_write         <= 1'b0;
      cache_entry_refill <= 1'b0;
      trans_rdy          <= 1'b0;
      bus_error          <= 1'b0;
      if (bus_fail_c) begin
        bus_req   <= 1'b0;
        bus_error <= 1'b1;
        trans_rdy <= 1'b1;
        state_q   <= ERR;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (write_line_req) begin
              state_q      <= WB_FETCH;
              tag_q        <= pa[63:OFS_W];
              addr_count   <= '0;
              fetch_wait_q <= 1'b1;
            end else if (read_line_req) begin
              state_q    <= RD_LINE;
              tag_q      <= pa[63:OFS_W];
              addr_count <= '0;
              bus_req    <= 1'b1;
              bus_we     <= 1'b0;
              bus_addr   <= beat_addr(pa[63:OFS_W], '0);
              bus_size   <= SIZE_DW;
            end else if (read_req) begin
              state_q  <= RD_ONE;
              bus_req  <= 1'b1;
              bus_we   <= 1'b0;
              bus_addr <= pa;
              bus_size <= L1_size;
            end else if (write_through_req) begin
              state_q   <= WR_ONE;
              bus_req   <= 1'b1;
              bus_we    <= 1'b1;
              bus_addr  <= pa;
              bus_size  <= L1_size;
              bus_wdata <= wt_data;
            end
          end
          RD_ONE, WR_ONE: begin
            if (bus_ok_c) begin
              if (state_q == RD_ONE) line_data <= bus_rdata;
              bus_req   <= 1'b0;
              trans_rdy <= 1'b1;
              state_q   <= DONE;
            end
          end
          RD_LINE: begin
            // Beat cycle: request/ack, then a line_write cycle that doubles as the bus gap.
            if (line_write) begin
              addr_count <= addr_count + CNT_W'(1);
              if (addr_count == LAST_BEAT) begin
                trans_rdy          <= 1'b1;
                cache_entry_refill <= 1'b1;
                state_q            <= DONE;
              end else begin
                bus_req  <= 1'b1;
                bus_addr <= beat_addr(tag_q, addr_count + CNT_W'(1));
              end
            end else if (bus_ok_c) begin
              line_data  <= bus_rdata;
              line_write <= 1'b1;
              bus_req    <= 1'b0;
            end
          end
          WB_FETCH: begin
            // Synchronous cache read: data for a new addr_count lands one cycle after it is seen.
            if (fetch_wait_q) begin
              fetch_wait_q <= 1'b0;
            end else begin
              bus_wdata <= wt_data;
              bus_req   <= 1'b1;
              bus_we    <= 1'b1;
              bus_addr  <= beat_addr(tag_q, addr_count);
              bus_size  <= SIZE_DW;
              state_q   <= WB_BEAT;
            end
          end
          WB_BEAT: begin
            if (bus_ok_c) begin
              bus_req    <= 1'b0;
              addr_count <= addr_count + CNT_W'(1);
              if (addr_count == LAST_BEAT) begin
                trans_rdy <= 1'b1;
                state_q   <= DONE;
              end else begin
                fetch_wait_q <= 1'b1;
                state_q      <= WB_FETCH;
              end
            end
          end
          DONE, ERR: state_q <= IDLE;
          default:   state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_l1d_line_ctrl.sv
// Bench for l1d_line_ctrl: bus responder, cache read model and a transaction-level reference model.
module tb_l1d_line_ctrl;

  localparam int unsigned LB  = 4;
  localparam int unsigned CW  = 2;
  localparam int unsigned TMO = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          write_through_req = 1'b0;
  logic          read_req = 1'b0;
  logic          read_line_req = 1'b0;
  logic          write_line_req = 1'b0;
  logic [3:0]    L1_size = 4'b1000;
  logic [63:0]   pa = '0;
  logic [63:0]   wt_data;
  logic [63:0]   wt_word = '0;
  logic [63:0]   cache_word = '0;
  logic          cache_mode = 1'b0;
  logic [63:0]   line_data;
  logic [CW-1:0] addr_count;
  logic          line_write, cache_entry_refill, trans_rdy, bus_error;
  logic          bus_req, bus_we;
  logic [63:0]   bus_addr, bus_wdata;
  logic [3:0]    bus_size;
  logic [63:0]   bus_rdata = '0;
  logic          bus_ack = 1'b0;
  logic          bus_err = 1'b0;

  assign wt_data = cache_mode ? cache_word : wt_word;

  l1d_line_ctrl #(.LINE_BEATS(LB), .CNT_W(CW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .write_through_req(write_through_req), .read_req(read_req),
    .read_line_req(read_line_req), .write_line_req(write_line_req),
    .L1_size(L1_size), .pa(pa), .wt_data(wt_data),
    .line_data(line_data), .addr_count(addr_count), .line_write(line_write),
    .cache_entry_refill(cache_entry_refill), .trans_rdy(trans_rdy), .bus_error(bus_error),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_size(bus_size),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; logic we; logic [3:0] size; logic [63:0] wdata; } beat_t;
  typedef struct { logic [CW-1:0] ac; logic [63:0] data; } lw_t;
  typedef struct { logic err; logic refill; logic [63:0] ld; logic [CW-1:0] ac; } rdy_t;

  beat_t beats[$];
  lw_t   lws[$];
  rdy_t  rdys[$];
  int    refill_cycles = 0;
  int    viol = 0;
  int    wait_cnt = 0;
  int    lat_r = 0;
  logic [CW-1:0] prev_ac = '0;

  // Environment knobs, written only by the stimulus block.
  int          fixed_lat = 2;
  bit          rand_lat = 1'b0;
  bit          no_ack = 1'b0;
  int          err_at = -1;
  int          rdata_mode = 0;
  logic [63:0] salt = '0;

  int vectors = 0;
  int miscompares = 0;
  logic [CW-1:0] m_ac = '0;
  logic [63:0]   m_ld = '0;

  function automatic logic [63:0] mem_rd(input logic [63:0] a, input int mode);
    case (mode)
      0:       return 64'hA0 + 64'(a[4:3]);
      1:       return 64'hDEAD_BEEF;
      default: return {a[31:0] ^ 32'h5EED_F00D, ~a[31:0]};
    endcase
  endfunction

  // Memory responder, cache read model and output recorder, all sampled at negedge.
  always @(negedge clk) begin
    if (line_write) lws.push_back('{addr_count, line_data});
    if (trans_rdy) rdys.push_back('{bus_error, cache_entry_refill, line_data, addr_count});
    if (cache_entry_refill) refill_cycles++;
    if (rst) begin
      bus_ack = 1'b0; bus_err = 1'b0; wait_cnt = 0;
    end else if (bus_ack || bus_err) begin
      if (bus_req) viol++;
      bus_ack = 1'b0; bus_err = 1'b0; wait_cnt = 0;
    end else if (bus_req && !no_ack) begin
      if (wait_cnt >= (rand_lat ? lat_r : fixed_lat)) begin
        if (err_at == beats.size()) bus_err = 1'b1;
        else begin
          bus_ack   = 1'b1;
          bus_rdata = mem_rd(bus_addr, rdata_mode);
        end
        beats.push_back('{bus_addr, bus_we, bus_size, bus_wdata});
        wait_cnt = 0;
        lat_r = int'($urandom_range(0, 3));
      end else begin
        wait_cnt++;
      end
    end
    cache_word = 64'hB0 + salt + 64'(prev_ac);
    prev_ac = addr_count;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drop_reqs();
    write_line_req = 1'b0; read_line_req = 1'b0; read_req = 1'b0; write_through_req = 1'b0;
  endtask

  task automatic wait_rdy(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (trans_rdy) seen = 1'b1;
    end
  endtask

  // reqs = {write_line, read_line, read, write_through}; err_k = beat index that gets bus_err, -1 none.
  task automatic run_txn(input logic [3:0] reqs, input int err_k);
    int kind, nb, nl, nr, nrf, nbeats, issued, done_n;
    bit seen, is_err;
    logic [63:0] base, a;
    kind   = reqs[3] ? 3 : reqs[2] ? 2 : reqs[1] ? 1 : 0;
    nbeats = (kind >= 2) ? int'(LB) : 1;
    is_err = (err_k >= 0) && (err_k < nbeats);
    issued = is_err ? err_k + 1 : nbeats;
    done_n = is_err ? err_k : nbeats;
    base   = pa & ~64'(LB * 8 - 1);
    nb = beats.size(); nl = lws.size(); nr = rdys.size(); nrf = refill_cycles;
    err_at     = is_err ? nb + err_k : -1;
    cache_mode = (kind == 3);
    write_line_req = reqs[3]; read_line_req = reqs[2]; read_req = reqs[1]; write_through_req = reqs[0];
    wait_rdy(seen);
    drop_reqs();
    repeat (3) @(negedge clk);
    err_at = -1;
    chk("rdy_seen", 64'(seen), 64'd1);
    chk("beat_count", 64'(beats.size() - nb), 64'(issued));
    for (int i = 0; i < issued && nb + i < beats.size(); i++) begin
      a = (kind >= 2) ? base + 64'(i * 8) : pa;
      chk("beat_addr", beats[nb + i].addr, a);
      chk("beat_we", 64'(beats[nb + i].we), 64'(kind == 3 || kind == 0));
      chk("beat_size", 64'(beats[nb + i].size), 64'((kind >= 2) ? 4'b1000 : L1_size));
      if (kind == 3) chk("wb_wdata", beats[nb + i].wdata, 64'hB0 + salt + 64'(i));
      if (kind == 0) chk("wt_wdata", beats[nb + i].wdata, wt_word);
    end
    chk("lw_count", 64'(lws.size() - nl), 64'((kind == 2) ? done_n : 0));
    for (int i = 0; kind == 2 && i < done_n && nl + i < lws.size(); i++) begin
      chk("lw_index", 64'(lws[nl + i].ac), 64'(i));
      chk("lw_data", lws[nl + i].data, mem_rd(base + 64'(i * 8), rdata_mode));
    end
    if (!is_err) begin
      if (kind == 1) m_ld = mem_rd(pa, rdata_mode);
      else if (kind == 2) m_ld = mem_rd(base + 64'((LB - 1) * 8), rdata_mode);
    end else if (kind == 2 && err_k > 0) begin
      m_ld = mem_rd(base + 64'((err_k - 1) * 8), rdata_mode);
    end
    if (kind >= 2) m_ac = CW'(done_n);
    chk("rdy_count", 64'(rdys.size() - nr), 64'd1);
    if (rdys.size() > nr) begin
      chk("rdy_bus_error", 64'(rdys[nr].err), 64'(is_err));
      chk("rdy_refill", 64'(rdys[nr].refill), 64'(kind == 2 && !is_err));
      chk("rdy_line_data", rdys[nr].ld, m_ld);
      chk("rdy_addr_count", 64'(rdys[nr].ac), 64'(m_ac));
    end
    chk("refill_cycles", 64'(refill_cycles - nrf), 64'(kind == 2 && !is_err));
    chk("bus_req_drop", 64'(viol), 64'd0);
  endtask

  initial begin
    int nb0, nr0, cnt, k, err_k;
    bit seen;
    logic [3:0] reqs;

    // Reset values
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(|{line_data, addr_count, line_write, cache_entry_refill, trans_rdy,
                               bus_error, bus_req, bus_we, bus_addr, bus_size, bus_wdata}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_bus_req", 64'(bus_req), 64'd0);

    // Line read, 2-cycle ack, A0..A3
    rdata_mode = 0; fixed_lat = 2; pa = 64'h1238;
    run_txn(4'b0100, -1);
    // Line write-back, cache returns B0+addr_count
    salt = '0; pa = 64'h1238;
    run_txn(4'b1000, -1);
    chk("wb_addr_count_wraps", 64'(addr_count), 64'd0);
    // Single read
    rdata_mode = 1; pa = 64'h40; L1_size = 4'b0100;
    run_txn(4'b0010, -1);
    // Single write-through
    wt_word = 64'h0123_4567_89AB_CDEF; pa = 64'h88; L1_size = 4'b0010;
    run_txn(4'b0001, -1);
    // Write-back wins over line read; line read follows on re-request
    rdata_mode = 0; salt = 64'h100; pa = 64'h2000; fixed_lat = 1;
    run_txn(4'b1100, -1);
    run_txn(4'b0100, -1);
    // bus_err on beat 2 of a line read
    pa = 64'h3010;
    run_txn(4'b0100, 2);
    chk("err_then_idle", 64'({bus_req, trans_rdy, bus_error}), 64'd0);

    // Reset in the middle of a write-back
    salt = 64'h40; pa = 64'h4000; cache_mode = 1'b1;
    nb0 = beats.size(); nr0 = rdys.size();
    write_line_req = 1'b1;
    for (int i = 0; i < 200 && beats.size() < nb0 + 2; i++) @(negedge clk);
    chk("rst_wb_progress", 64'(beats.size() >= nb0 + 2), 64'd1);
    rst = 1'b1;
    drop_reqs();
    @(negedge clk);
    chk("rst_mid_outputs", 64'(|{line_data, addr_count, line_write, cache_entry_refill, trans_rdy,
                                 bus_error, bus_req, bus_we, bus_addr, bus_size, bus_wdata}), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_no_completion", 64'(rdys.size() - nr0), 64'd0);
    m_ac = '0; m_ld = '0;

`ifdef L1C_BUS_TIMEOUT_EN
    // Watchdog: no ack ever arrives
    no_ack = 1'b1; pa = 64'h80; L1_size = 4'b0001; cache_mode = 1'b0;
    cnt = 0; seen = 1'b0;
    read_req = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus_req) cnt++;
      if (bus_error) seen = 1'b1;
    end
    drop_reqs();
    chk("tmo_seen", 64'(seen), 64'd1);
    chk("tmo_wait_cycles", 64'(cnt), 64'(TMO));
    chk("tmo_trans_rdy", 64'(trans_rdy), 64'd1);
    repeat (3) @(negedge clk);
    no_ack = 1'b0;
`endif

    // Randomized transactions
    rand_lat = 1'b1; rdata_mode = 2;
    for (int t = 0; t < 40; t++) begin
      reqs    = 4'($urandom_range(1, 15));
      pa      = {$urandom, $urandom};
      L1_size = 4'(1 << $urandom_range(0, 3));
      wt_word = {$urandom, $urandom};
      salt    = {$urandom, $urandom};
      k       = (reqs[3] || reqs[2]) ? int'(LB) : 1;
      err_k   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, k - 1)) : -1;
      run_txn(reqs, err_k);
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/l1d_line_ctrl.md
Name: l1d_line_ctrl

Overview:
- Cache/bus controller directly downstream of the L1 data cache.
- Consumes the L1 request strobes: write-through, single read, line read, line write-back.
- Sequences them as single-beat transfers on a simple 64-bit req/ack memory bus.
- Returns line beats, beat index, write strobes, refill/ready/error pulses to the L1.

Parameters:
- LINE_BEATS, 2048, 64-bit beats per cache line; power of two, >=2.
- CNT_W, 11, width of addr_count; must equal log2(LINE_BEATS).
- TIMEOUT, 255, ack watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- write_through_req  in  1  single write of wt_data at pa
- read_req  in  1  single read at pa
- read_line_req  in  1  fetch full line containing pa
- write_line_req  in  1  write back full line containing pa
- L1_size  in  4  access size, one-hot 1/2/4/8 bytes
- pa  in  64  physical address
- wt_data  in  64  write data; during write-back, cache read data for addr_count, valid 1 cycle after addr_count changes
- line_data  out  64  registered read beat
- addr_count  out  CNT_W  current beat index within line
- line_write  out  1  write line_data into cache at addr_count
- cache_entry_refill  out  1  line fetch complete, update tag
- trans_rdy  out  1  transaction complete
- bus_error  out  1  transaction failed
- bus_req  out  1  bus beat request, held until ack/err
- bus_we  out  1  1 = write beat
- bus_addr  out  64  beat address
- bus_size  out  4  beat size, one-hot
- bus_wdata  out  64  write data
- bus_rdata  in  64  read data, valid with bus_ack
- bus_ack  in  1  beat accepted/completed
- bus_err  in  1  beat failed; takes priority over bus_ack

Behaviour:
- Reset: state IDLE. All outputs 0: line_data, addr_count, line_write, cache_entry_refill, trans_rdy, bus_error, bus_req, bus_we, bus_addr, bus_size, bus_wdata.
- Reset mid-transfer aborts immediately. bus_req drops the next cycle; no completion pulse is issued.
- States: IDLE, RD_ONE, WR_ONE, RD_LINE, WB_FETCH, WB_BEAT, DONE, ERR.
- IDLE arbitration, highest first: write_line_req > read_line_req > read_req > write_through_req.
  - Requests are levels. Sampled only in IDLE.
  - Entering a line state clears addr_count to 0.
- Line base address = {pa[63:log2(LINE_BEATS*8)], 0}. Beat address = base + addr_count*8. Line beats use bus_size=4'b1000.
- RD_ONE / WR_ONE:
  - bus_req=1, bus_addr=pa, bus_size=L1_size, bus_we=WR_ONE.
  - WR_ONE: bus_wdata = wt_data captured on entry.
  - On ack: RD_ONE registers bus_rdata into line_data. Then go to DONE.
- RD_LINE:
  - One request per beat.
  - On ack: line_data<=bus_rdata; line_write pulses 1 cycle later with addr_count still at that beat; then addr_count increments.
  - After beat LINE_BEATS-1: go to DONE; cache_entry_refill pulses concurrently with trans_rdy.
- WB_FETCH: one-cycle wait so cache read data for addr_count appears on wt_data.
- WB_BEAT:
  - bus_we=1, bus_wdata=wt_data registered at WB_FETCH exit.
  - On ack: increment addr_count, return to WB_FETCH.
  - After the last beat: go to DONE.
- DONE: trans_rdy=1 for exactly one cycle, then IDLE. The L1 drops its request on that same edge, so IDLE never re-triggers on a stale request.
- bus_err in any bus state: go to ERR. bus_error=1 and trans_rdy=1 for one cycle, then IDLE. No further beats; no refill pulse.
- addr_count wraps to 0 after the last beat. It holds its value in IDLE.
- bus_req deasserts the cycle after ack/err. Minimum one idle bus cycle between beats.
- Requests changing while busy are ignored.

Optional Feature:
- Macro L1C_BUS_TIMEOUT_EN.
- Defined: an 8-bit+ counter runs while bus_req=1 and no ack. Reaching TIMEOUT forces the ERR path exactly as bus_err would. The counter clears on every ack.
- Undefined: no counter; the block waits indefinitely for ack/err.

Test Plan:
- LINE_BEATS=4, read_line_req, pa=0x1238, memory returns 0xA0..0xA3 with 2-cycle ack latency -> bus_addr 0x1220,0x1228,0x1230,0x1238; line_write x4 with addr_count 0..3 and line_data A0..A3; one cycle with cache_entry_refill=trans_rdy=1.
- write_line_req, LINE_BEATS=4, cache model returns wt_data=0xB0+addr_count one cycle late -> four bus writes carrying B0..B3 to consecutive addresses; trans_rdy once; addr_count ends 0.
- read_req pa=0x40, L1_size=4'b0100, bus_rdata=0xDEADBEEF -> bus_size=0100, line_data=0xDEADBEEF with trans_rdy; no line_write.
- write_line_req and read_line_req asserted together -> write-back executes first; read_line issued after the L1 re-requests.
- bus_err on beat 2 of a line read -> bus_error=trans_rdy=1 one cycle; cache_entry_refill never set; IDLE next cycle.
- rst asserted mid write-back, then with L1C_BUS_TIMEOUT_EN and TIMEOUT=10 and no ack -> outputs zero after reset; bus_error at the 10th wait cycle.
